// File: rtl/cmos_dvp_capture_pkg.sv
// Shared types and helpers for the OV5640 DVP capture path.
// Holds the capture state encoding, the RGB565 field layout and the saturating counter helper.
package cmos_dvp_capture_pkg;

  typedef enum logic [1:0] {
    WAIT_CFG = 2'd0,
    SKIP     = 2'd1,
    ACTIVE   = 2'd2
  } cap_state_e;

  localparam int FRAME_SKIP_DEFAULT = 10;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  // The high byte carries R and the top of G; the low byte carries the rest of G and B.
  function automatic logic [15:0] pack_rgb565(input logic [7:0] hi, input logic [7:0] lo);
    logic [15:0] p;
    p = '0;
    p[R_MSB:R_LSB] = hi[7:3];
    p[G_MSB:G_LSB] = {hi[2:0], lo[7:5]};
    p[B_MSB:B_LSB] = lo[4:0];
    return p;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cmos_dvp_capture_sync2.sv
// Generic two-flop synchronizer with synchronous active-low reset.
// Brings a slow level signal into the clk_i domain.
module cmos_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cmos_dvp_capture.sv
// OV5640 DVP capture: skips settling frames, packs byte pairs into RGB565 pixels,
// flags start-of-frame / end-of-line, and checks line/frame geometry.
module cmos_dvp_capture
  import cmos_dvp_capture_pkg::*;
#(
  parameter int FRAME_SKIP = FRAME_SKIP_DEFAULT,
  parameter bit BYTE_SWAP  = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        cfg_done,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  input  logic [15:0] CAM_HSIZE,
  input  logic [15:0] CAM_VSIZE,
  output logic [15:0] pix_data,
  output logic        pix_vld,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic [15:0] frame_cnt,
  output logic        line_err,
  output logic        frame_err,
  output logic        cap_busy
);

  cap_state_e  state;
  logic        cfg_s;
  logic        vs_r, vs_rr, href_r, href_rr;
  logic [7:0]  d_r;
  logic [7:0]  first_byte;
  logic        phase;
  logic        sof_pending;
  logic [7:0]  skip_cnt;
  logic [15:0] line_cnt;
  logic [15:0] hcnt;

  logic        vs_rise, href_fall, pix_en;
  logic [15:0] line_cnt_upd;
  logic [15:0] hsize_m1;
  logic [15:0] px;

  cmos_sync2 #(.WIDTH(1)) u_cfg_sync (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .d     (cfg_done),
    .q     (cfg_s)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      vs_r    <= 1'b0;
      vs_rr   <= 1'b0;
      href_r  <= 1'b0;
      href_rr <= 1'b0;
      d_r     <= '0;
    end else begin
      vs_r    <= cmos_vsync;
      vs_rr   <= vs_r;
      href_r  <= cmos_href;
      href_rr <= href_r;
      d_r     <= cmos_data;
    end
  end

  // A line only counts if it ran while vsync was low; gating on vs_rr keeps a
  // line that ends exactly on a vsync rise.
  assign vs_rise      = vs_r & ~vs_rr;
  assign href_fall    = href_rr & ~href_r & ~vs_rr;
  assign pix_en       = href_r & ~vs_r;
  assign line_cnt_upd = href_fall ? sat_inc16(line_cnt) : line_cnt;
  assign hsize_m1     = CAM_HSIZE - 16'd1;
  assign px           = BYTE_SWAP ? pack_rgb565(d_r, first_byte) : pack_rgb565(first_byte, d_r);

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state       <= WAIT_CFG;
      skip_cnt    <= '0;
      line_cnt    <= '0;
      hcnt        <= '0;
      phase       <= 1'b0;
      first_byte  <= '0;
      sof_pending <= 1'b0;
      pix_data    <= '0;
      pix_vld     <= 1'b0;
      pix_sof     <= 1'b0;
      pix_eol     <= 1'b0;
      frame_cnt   <= '0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
      cap_busy    <= 1'b0;
    end else begin
      pix_vld <= 1'b0;
      pix_sof <= 1'b0;
      pix_eol <= 1'b0;
      case (state)
        WAIT_CFG: begin
          cap_busy <= 1'b0;
          if (cfg_s) begin
            state    <= SKIP;
            skip_cnt <= '0;
          end
        end
        SKIP: begin
          if (!cfg_s) begin
            state    <= WAIT_CFG;
            cap_busy <= 1'b0;
          end else if (vs_rise) begin
            if (skip_cnt == 8'(FRAME_SKIP)) begin
              state       <= ACTIVE;
              cap_busy    <= 1'b1;
              frame_cnt   <= frame_cnt + 16'd1;
              line_cnt    <= '0;
              sof_pending <= 1'b1;
              hcnt        <= '0;
              phase       <= 1'b0;
            end else begin
              skip_cnt <= skip_cnt + 8'd1;
            end
          end
        end
        ACTIVE: begin
          if (!cfg_s) begin
            state    <= WAIT_CFG;
            cap_busy <= 1'b0;
            phase    <= 1'b0;
            hcnt     <= '0;
          end else begin
            if (href_fall) begin
              if (phase || (hcnt != CAM_HSIZE)) line_err <= 1'b1;
              hcnt  <= '0;
              phase <= 1'b0;
            end else if (pix_en) begin
              if (!phase) begin
                first_byte <= d_r;
                phase      <= 1'b1;
              end else begin
                pix_data    <= px;
                pix_vld     <= 1'b1;
                pix_sof     <= sof_pending;
                pix_eol     <= (hcnt == hsize_m1);
                sof_pending <= 1'b0;
                hcnt        <= sat_inc16(hcnt);
                phase       <= 1'b0;
              end
            end
            line_cnt <= line_cnt_upd;
            // Frame check sees the line that may have closed on this same edge.
            if (vs_rise) begin
              if (line_cnt_upd != CAM_VSIZE) frame_err <= 1'b1;
              frame_cnt   <= frame_cnt + 16'd1;
              line_cnt    <= '0;
              sof_pending <= 1'b1;
              hcnt        <= '0;
              phase       <= 1'b0;
            end
          end
        end
        default: begin
          state    <= WAIT_CFG;
          cap_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmos_dvp_capture.sv
// Directed bench for cmos_dvp_capture with a pixel scoreboard; a second
// instance with swapped byte order shares the same stimulus.
module tb_cmos_dvp_capture;

  localparam int W = 18;

  logic        clk = 1'b0;
  logic        rst_n, cfg_done, cmos_vsync, cmos_href;
  logic [7:0]  cmos_data;
  logic [15:0] cam_hsize, cam_vsize;

  logic [15:0] pix_data, frame_cnt;
  logic        pix_vld, pix_sof, pix_eol, line_err, frame_err, cap_busy;
  logic [15:0] sw_data, sw_fcnt;
  logic        sw_vld, sw_sof, sw_eol, sw_lerr, sw_ferr, sw_busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int vld_cnt  = 0;
  int vld_mark;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  bit           capture  = 1'b0;
  bit           sof_pend = 1'b0;

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cmos_dvp_capture #(.FRAME_SKIP(2), .BYTE_SWAP(1'b0)) dut (
    .clk_i(clk), .rst_n(rst_n), .cfg_done(cfg_done), .cmos_vsync(cmos_vsync),
    .cmos_href(cmos_href), .cmos_data(cmos_data), .CAM_HSIZE(cam_hsize), .CAM_VSIZE(cam_vsize),
    .pix_data(pix_data), .pix_vld(pix_vld), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .frame_cnt(frame_cnt), .line_err(line_err), .frame_err(frame_err), .cap_busy(cap_busy)
  );

  cmos_dvp_capture #(.FRAME_SKIP(2), .BYTE_SWAP(1'b1)) dut_swap (
    .clk_i(clk), .rst_n(rst_n), .cfg_done(cfg_done), .cmos_vsync(cmos_vsync),
    .cmos_href(cmos_href), .cmos_data(cmos_data), .CAM_HSIZE(cam_hsize), .CAM_VSIZE(cam_vsize),
    .pix_data(sw_data), .pix_vld(sw_vld), .pix_sof(sw_sof), .pix_eol(sw_eol),
    .frame_cnt(sw_fcnt), .line_err(sw_lerr), .frame_err(sw_ferr), .cap_busy(sw_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input logic [15:0] fc, input logic busy, input logic le, input logic fe);
    check("frame_cnt", frame_cnt, fc);
    check("cap_busy", cap_busy, busy);
    check("line_err", line_err, le);
    check("frame_err", frame_err, fe);
    check("swap_frame_cnt", sw_fcnt, fc);
    check("swap_cap_busy", sw_busy, busy);
    check("swap_line_err", sw_lerr, le);
    check("swap_frame_err", sw_ferr, fe);
  endtask

  // Scoreboard: every output pixel must match the oldest expected entry
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    int           l;
    if (pix_vld === 1'b1) begin
      vld_cnt++;
      check("pix_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        check("pix_data", pix_data, e[17:2]);
        check("pix_sof", pix_sof, e[1]);
        check("pix_eol", pix_eol, e[0]);
        check("pix_latency", cyc, l);
        check("swap_vld", sw_vld, 1'b1);
        check("swap_data", sw_data, {e[9:2], e[17:10]});
        check("swap_sof", sw_sof, e[1]);
        check("swap_eol", sw_eol, e[0]);
      end
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic vsync_pulse();
    if (capture) sof_pend = 1'b1;
    cmos_vsync = 1'b1;
    tick(3);
    cmos_vsync = 1'b0;
    tick(3);
  endtask

  task automatic send_bytes(input int nbytes, input bit fixed);
    logic [7:0] b, first;
    first = '0;
    for (int i = 0; i < nbytes; i++) begin
      if (fixed && i == 0)      b = 8'hF8;
      else if (fixed && i == 1) b = 8'h1F;
      else                      b = 8'($urandom_range(0, 255));
      if (i % 2 == 0) begin
        first = b;
      end else if (capture) begin
        exp_q.push_back({first, b, sof_pend, (i / 2) == (int'(cam_hsize) - 1)});
        lat_q.push_back(cyc + 2);
        sof_pend = 1'b0;
      end
      cmos_href = 1'b1;
      cmos_data = b;
      tick(1);
    end
  endtask

  task automatic send_line(input int nbytes, input bit fixed);
    send_bytes(nbytes, fixed);
    cmos_href = 1'b0;
    cmos_data = '0;
    tick(4);
  endtask

  initial begin
    rst_n      = 1'b0;
    cfg_done   = 1'b0;
    cmos_vsync = 1'b0;
    cmos_href  = 1'b0;
    cmos_data  = '0;
    cam_hsize  = 16'd4;
    cam_vsize  = 16'd2;
    tick(3);

    // Reset state
    check("rst_pix_data", pix_data, 16'h0);
    check("rst_pix_vld", pix_vld, 1'b0);
    check("rst_pix_sof", pix_sof, 1'b0);
    check("rst_pix_eol", pix_eol, 1'b0);
    check_status(16'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(4);
    check("wait_cfg_busy", cap_busy, 1'b0);

    // Two settling frames, then two captured 2x4 frames
    cfg_done = 1'b1;
    tick(5);
    vsync_pulse();
    send_line(8, 1'b0);
    send_line(8, 1'b0);
    vsync_pulse();
    send_line(8, 1'b0);
    send_line(8, 1'b0);
    check_status(16'd0, 1'b0, 1'b0, 1'b0);
    check("skip_no_pixels", vld_cnt, 0);
    capture = 1'b1;
    vsync_pulse();
    check_status(16'd1, 1'b1, 1'b0, 1'b0);
    send_line(8, 1'b1);
    send_line(8, 1'b0);
    vsync_pulse();
    check_status(16'd2, 1'b1, 1'b0, 1'b0);
    send_line(8, 1'b0);
    send_line(8, 1'b0);
    check("two_frames_pixels", vld_cnt, 16);
    check_status(16'd2, 1'b1, 1'b0, 1'b0);

    // Configuration lost between lines, then restored: skipping restarts from zero
    cfg_done = 1'b0;
    tick(3);
    check_status(16'd2, 1'b0, 1'b0, 1'b0);
    capture  = 1'b0;
    vld_mark = vld_cnt;
    send_line(8, 1'b0);
    check("cfg_lost_no_pixels", vld_cnt, vld_mark);
    cfg_done = 1'b1;
    tick(5);
    vsync_pulse();
    send_line(8, 1'b0);
    vsync_pulse();
    check_status(16'd2, 1'b0, 1'b0, 1'b0);
    check("reskip_no_pixels", vld_cnt, vld_mark);
    capture = 1'b1;
    vsync_pulse();
    check_status(16'd3, 1'b1, 1'b0, 1'b0);
    send_line(8, 1'b0);
    send_line(8, 1'b0);

    // Odd byte count line, then three lines in a two-line frame
    send_line(7, 1'b0);
    check_status(16'd3, 1'b1, 1'b1, 1'b0);
    vsync_pulse();
    check_status(16'd4, 1'b1, 1'b1, 1'b1);

    // Reset mid-line after three bytes
    send_bytes(3, 1'b0);
    rst_n = 1'b0;
    tick(1);
    rst_n     = 1'b1;
    cmos_href = 1'b0;
    cmos_data = '0;
    capture   = 1'b0;
    check("midrst_pix_vld", pix_vld, 1'b0);
    check("midrst_pix_data", pix_data, 16'h0);
    check("midrst_pix_sof", pix_sof, 1'b0);
    check("midrst_pix_eol", pix_eol, 1'b0);
    check_status(16'd0, 1'b0, 1'b0, 1'b0);
    vld_mark = vld_cnt;
    tick(5);
    vsync_pulse();
    send_line(8, 1'b0);
    vsync_pulse();
    send_line(8, 1'b0);
    check("post_rst_skip_pixels", vld_cnt, vld_mark);
    check_status(16'd0, 1'b0, 1'b0, 1'b0);
    capture = 1'b1;
    vsync_pulse();
    check_status(16'd1, 1'b1, 1'b0, 1'b0);

    // Short line: three pixels against a four-pixel width
    send_line(6, 1'b0);
    check_status(16'd1, 1'b1, 1'b1, 1'b0);
    check("short_line_pixels", vld_cnt, vld_mark + 3);

    tick(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
